condicionador_sensores: RTL and testbench

- Input conditioning stage that sits directly upstream of the terminal output selector.
- Takes the six raw, asynchronous sensor/switch lines and synchronises each one to CLK, then debounces each one independently.
- Presents six stable, registered levels A..F that the selector consumes unchanged.
- Also provides a one-cycle change strobe and a pending flag for monitoring and test.

---
 rtl/condicionador_sensores_pkg.sv | 22 ++
 rtl/condicionador_sensores_debounce_bit.sv | 55 +++++
 rtl/condicionador_sensores.sv | 78 +++++++
 tb/tb_condicionador_sensores.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/condicionador_sensores_pkg.sv
// Shared constants for the sensor input conditioning stage.
package condicionador_sensores_pkg;

  localparam int unsigned NUM_SENSORES = 6;

  // Bit positions of each sensor within RAW
  localparam int unsigned IDX_A = 5;
  localparam int unsigned IDX_B = 4;
  localparam int unsigned IDX_C = 3;
  localparam int unsigned IDX_D = 2;
  localparam int unsigned IDX_E = 1;
  localparam int unsigned IDX_F = 0;

  // Width of each per-bit debounce counter
  localparam int unsigned CNT_W = 8;

  // Prescaler counter width: clog2 of the divider, never below one bit
  function automatic int unsigned presc_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/condicionador_sensores_debounce_bit.sv
// One sensor line: two-flop synchroniser followed by a tick-paced debouncer.
// OUT only moves after the synchronised level has differed from it for
// DEBOUNCE_TICKS consecutive ticks; any return to the stable level cancels.
module debounce_bit
  import condicionador_sensores_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic TICK,
  input  logic SYNC_IN,
  output logic OUT,
  output logic CHANGE,
  output logic DIFF
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Synchronised level disagrees with the committed output
  assign DIFF   = (sync_q2 != OUT);
  // This edge commits the new level
  assign CHANGE = DIFF && TICK && (cnt == CNT_LAST);

  // Two-stage synchroniser for the asynchronous input
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= SYNC_IN;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce counter and committed output level
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
      OUT <= 1'b0;
    end else if (!DIFF) begin
      cnt <= '0;
    end else if (CHANGE) begin
      OUT <= sync_q2;
      cnt <= '0;
    end else if (TICK) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/condicionador_sensores.sv
// Input conditioning stage: synchronises and debounces six raw sensor lines
// and presents them as stable registered levels A..F, plus a one-cycle
// CHANGED strobe and a PENDING flag while any line is still settling.
module condicionador_sensores
  import condicionador_sensores_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_SENSORES-1:0] RAW,
  output logic                    A,
  output logic                    B,
  output logic                    C,
  output logic                    D,
  output logic                    E,
  output logic                    F,
  output logic                    CHANGED,
  output logic                    PENDING
);

  localparam int unsigned          PRESC_W    = presc_width(TICK_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]      presc;
  logic                    tick;
  logic [NUM_SENSORES-1:0] out_bits;
  logic [NUM_SENSORES-1:0] change_bits;
  logic [NUM_SENSORES-1:0] diff_bits;

  // With TICK_DIV=1 the counter is pinned at 0 and the tick never drops
  assign tick = (presc == PRESC_LAST);

  // Debounce tick prescaler, counts 0..TICK_DIV-1 and wraps
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SENSORES; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce_bit (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .TICK    (tick),
      .SYNC_IN (RAW[i]),
      .OUT     (out_bits[i]),
      .CHANGE  (change_bits[i]),
      .DIFF    (diff_bits[i])
    );
  end

  // Change strobe and settling flag, one cycle behind the bit state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CHANGED <= 1'b0;
      PENDING <= 1'b0;
    end else begin
      CHANGED <= |change_bits;
      PENDING <= |diff_bits;
    end
  end

  assign A = out_bits[IDX_A];
  assign B = out_bits[IDX_B];
  assign C = out_bits[IDX_C];
  assign D = out_bits[IDX_D];
  assign E = out_bits[IDX_E];
  assign F = out_bits[IDX_F];

endmodule

// File: tb/tb_condicionador_sensores.sv
// Bench for condicionador_sensores: a fast instance (TICK_DIV=1, DEBOUNCE_TICKS=4)
// checked through a CHANGED-driven scoreboard, and a prescaled instance
// (TICK_DIV=5, DEBOUNCE_TICKS=2) checked by latency measurement.
module tb_condicionador_sensores;

  typedef struct {
    int         at_cyc;
    logic [5:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] raw;
  logic       a, b, c, d, e, f, changed, pending;

  logic       rst2_n;
  logic [5:0] raw2;
  logic       a2, b2, c2, d2, e2, f2, changed2, pending2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  // Posedge counter: at a negedge, cyc equals the number of edges so far
  always @(posedge clk) cyc <= cyc + 1;

  condicionador_sensores #(
    .TICK_DIV       (1),
    .DEBOUNCE_TICKS (4)
  ) u_dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .RAW     (raw),
    .A       (a),
    .B       (b),
    .C       (c),
    .D       (d),
    .E       (e),
    .F       (f),
    .CHANGED (changed),
    .PENDING (pending)
  );

  condicionador_sensores #(
    .TICK_DIV       (5),
    .DEBOUNCE_TICKS (2)
  ) u_dut_presc (
    .CLK     (clk),
    .RESET_N (rst2_n),
    .RAW     (raw2),
    .A       (a2),
    .B       (b2),
    .C       (c2),
    .D       (d2),
    .E       (e2),
    .F       (f2),
    .CHANGED (changed2),
    .PENDING (pending2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t cyc=%0d)", name, act, req, $time, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_change(input int at_cyc, input logic [5:0] v);
    exp_t x;
    x.at_cyc = at_cyc;
    x.val    = v;
    q.push_back(x);
  endtask

  task automatic count_pending(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (pending === 1'b1) hits++;
    end
  endtask

  // Wait up to 20 cycles for f2 to reach lvl; returns cycles taken or -1
  task automatic wait_f2(input logic lvl, output int lat);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (f2 === lvl) lat = i;
    end
  endtask

  // Scoreboard monitor: every CHANGED pulse must match the next expected commit
  always @(negedge clk) begin
    exp_t x;
    if (rst_n === 1'b1 && changed === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_changed: pulse at cyc=%0d outputs=%b, required no pulse",
                 cyc, {a, b, c, d, e, f});
      end else begin
        x = q.pop_front();
        check("changed_cycle", cyc, x.at_cyc);
        check("changed_outputs", {26'd0, a, b, c, d, e, f}, {26'd0, x.val});
      end
    end
  end

  initial begin
    int h, h1, h2, lat;

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    raw    = 6'b111111;
    raw2   = 6'b000000;

    // Reset held with all inputs high
    wait_cyc(4);
    check("reset_outputs", {26'd0, a, b, c, d, e, f}, 32'd0);
    check("reset_changed", changed, 1'b0);
    check("reset_pending", pending, 1'b0);

    raw = 6'b000000;
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(3);

    // Clean step on A: commit 6 edges later, PENDING for 4 cycles
    raw = 6'b100000;
    expect_change(cyc + 6, 6'b100000);
    count_pending(10, h);
    check("step_pending_cycles", h, 4);

    raw = 6'b000000;
    expect_change(cyc + 6, 6'b000000);
    count_pending(10, h);
    check("fall_pending_cycles", h, 4);

    // Three-cycle glitch on D: rejected, PENDING for 3 cycles
    raw = 6'b000100;
    count_pending(3, h1);
    raw = 6'b000000;
    count_pending(9, h2);
    check("glitch_pending_cycles", h1 + h2, 3);
    check("glitch_d_level", d, 1'b0);

    // Four-cycle pulse on D: accepted, then released again
    raw = 6'b000100;
    expect_change(cyc + 6, 6'b000100);
    expect_change(cyc + 10, 6'b000000);
    wait_cyc(4);
    raw = 6'b000000;
    wait_cyc(10);

    // Simultaneous rise on B, D, F: one CHANGED pulse
    raw = 6'b010101;
    expect_change(cyc + 6, 6'b010101);
    wait_cyc(10);

    // Bounce train on E, then a stable high
    for (int i = 0; i < 5; i++) begin
      raw[1] = 1'b1;
      wait_cyc(2);
      raw[1] = 1'b0;
      wait_cyc(2);
    end
    raw[1] = 1'b1;
    expect_change(cyc + 6, 6'b010111);
    wait_cyc(10);
    check("bounce_e_level", e, 1'b1);

    // Asynchronous reset between edges while outputs are set and settling
    raw = 6'b000000;
    wait_cyc(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_outputs", {26'd0, a, b, c, d, e, f}, 32'd0);
    check("async_changed", changed, 1'b0);
    check("async_pending", pending, 1'b0);
    wait_cyc(2);
    check("scoreboard_drained", q.size(), 0);

    // Prescaled instance: step, then reset mid-debounce
    rst2_n = 1'b1;
    wait_cyc(3);
    raw2 = 6'b000001;
    wait_cyc(6);
    check("presc_mid_f", f2, 1'b0);
    rst2_n = 1'b0;
    #1;
    check("presc_async_f", f2, 1'b0);
    check("presc_async_pending", pending2, 1'b0);
    wait_cyc(2);
    rst2_n = 1'b1;
    // Ticks land on edges 5, 10, ... after release; sync is ready by edge 3
    wait_f2(1'b1, lat);
    check("presc_restart_latency", lat, 10);

    raw2 = 6'b000000;
    wait_f2(1'b0, lat);
    check_range("presc_fall_latency", lat, 8, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
